// File: rtl/bf_board_overseer.sv
// Board glue for the brainfuck core: input sync/debounce, UART tick, reset sequencing, status LED.
// Optional watchdog (S_TIMEOUT, timeout output) is enabled by defining BF_OVERSEER_WATCHDOG_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_RESET   | core_rst_n asserted
// S_LOAD    | core out of reset, loading switch on
// S_RUN     | program executing
// S_DONE    | core raised done; held until core reset or loading
// S_TIMEOUT | watchdog expired in S_RUN (watchdog build only)
module bf_board_overseer #(
    parameter int CLK_HZ          = 12000000,
    parameter int UART_HZ         = 1000000,
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int RESET_HOLD      = 16,
    parameter int BLINK_BITS      = 22,
    parameter int WDT_BITS        = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sw_in,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             rx_in,
    input  logic             done,
    output logic             rx_sync,
    output logic [N_BTN-1:0] btn_db,
    output logic             loading,
    output logic             uart_en,
    output logic             main_rst_n,
    output logic             core_rst_n,
    output logic [2:0]       led_rgb,
    output logic             timeout
);

    localparam int DIV    = CLK_HZ / UART_HZ;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [N_BTN+1:0]  SYNC_INIT = {1'b1, {(N_BTN + 1){1'b0}}};

    typedef enum logic [2:0] {
        S_RESET,
        S_LOAD,
        S_RUN,
        S_DONE
`ifdef BF_OVERSEER_WATCHDOG_EN
        , S_TIMEOUT
`endif
    } state_t;

    // Sync chain layout: {rx, sw, btn[N_BTN-1:0]}; rx idles high.
    logic [N_BTN+1:0] sync_q1, sync_q2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= SYNC_INIT;
            sync_q2 <= SYNC_INIT;
        end else begin
            sync_q1 <= {rx_in, sw_in, btn_in};
            sync_q2 <= sync_q1;
        end
    end

    assign rx_sync = sync_q2[N_BTN+1];

    logic [N_BTN:0]           db_in, db_q, db_d;
    logic [N_BTN:0][DB_W-1:0] db_cnt_q, db_cnt_d;

    assign db_in = sync_q2[N_BTN:0];

    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i <= N_BTN; i++) begin
            if (db_in[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = db_in[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q     <= '0;
            db_cnt_q <= '0;
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign loading = db_q[N_BTN];
    assign btn_db  = db_q[N_BTN-1:0];

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            uart_en <= 1'b0;
        end else begin
            uart_en <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // A cause asserts reset on the edge it appears (next value) and keeps the
    // hold counter cleared for as long as the registered cause is still high.
    logic              main_cause, core_cause, load_fall;
    logic [HOLD_W-1:0] main_cnt, core_cnt;

    assign load_fall  = db_q[N_BTN] & ~db_d[N_BTN];
    assign main_cause = db_d[1] | db_q[1];
    assign core_cause = main_cause | ~main_rst_n | db_d[0] | db_q[0] | load_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_rst_n <= 1'b0;
            main_cnt   <= '0;
        end else if (main_cause) begin
            main_rst_n <= 1'b0;
            main_cnt   <= '0;
        end else if (!main_rst_n) begin
            if (main_cnt == HOLD_LAST) begin
                main_rst_n <= 1'b1;
                main_cnt   <= '0;
            end else begin
                main_cnt <= main_cnt + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_rst_n <= 1'b0;
            core_cnt   <= '0;
        end else if (core_cause) begin
            core_rst_n <= 1'b0;
            core_cnt   <= '0;
        end else if (!core_rst_n) begin
            if (core_cnt == HOLD_LAST) begin
                core_rst_n <= 1'b1;
                core_cnt   <= '0;
            end else begin
                core_cnt <= core_cnt + HOLD_W'(1);
            end
        end
    end

    state_t     state, state_d;
    logic [2:0] led_d;

`ifdef BF_OVERSEER_WATCHDOG_EN
    logic [WDT_BITS-1:0]   wdt_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  blink;

    assign blink = blink_cnt[BLINK_BITS-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdt_cnt   <= '0;
            blink_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            wdt_cnt   <= (state == S_RUN) ? wdt_cnt + WDT_BITS'(1) : '0;
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
            timeout   <= (state == S_TIMEOUT);
        end
    end
`else
    localparam int unused_params = BLINK_BITS + WDT_BITS;

    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = S_RUN;
        led_d   = 3'b000;
        if (!core_rst_n) begin
            state_d = S_RESET;
        end else if (loading) begin
            state_d = S_LOAD;
`ifdef BF_OVERSEER_WATCHDOG_EN
        end else if (state == S_TIMEOUT || (state == S_RUN && wdt_cnt == '1)) begin
            state_d = S_TIMEOUT;
`endif
        end else if (done || state == S_DONE) begin
            state_d = S_DONE;
        end
        case (state)
            S_LOAD:    led_d = 3'b010;
            S_RUN:     led_d = 3'b100;
            S_DONE:    led_d = 3'b001;
`ifdef BF_OVERSEER_WATCHDOG_EN
            S_TIMEOUT: led_d = {blink, 2'b00};
`endif
            default:   led_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_RESET;
            led_rgb <= 3'b000;
        end else begin
            state   <= state_d;
            led_rgb <= led_d;
        end
    end

endmodule

// File: tb/tb_bf_board_overseer.sv
// Scoreboard bench for bf_board_overseer: the driver queues expected output values
// tagged with the cycle they must appear on; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_bf_board_overseer;

    localparam int N_BTN = 2;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             sw_in   = 1'b0;
    logic [N_BTN-1:0] btn_in  = '0;
    logic             rx_in   = 1'b0;
    logic             done    = 1'b0;
    logic             rx_sync;
    logic [N_BTN-1:0] btn_db;
    logic             loading;
    logic             uart_en;
    logic             main_rst_n;
    logic             core_rst_n;
    logic [2:0]       led_rgb;
    logic             timeout;

    bf_board_overseer #(
        .CLK_HZ(12), .UART_HZ(3), .N_BTN(N_BTN), .DEBOUNCE_CYCLES(4),
        .RESET_HOLD(3), .BLINK_BITS(2), .WDT_BITS(6)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sw_in(sw_in), .btn_in(btn_in),
        .rx_in(rx_in), .done(done), .rx_sync(rx_sync), .btn_db(btn_db),
        .loading(loading), .uart_en(uart_en), .main_rst_n(main_rst_n),
        .core_rst_n(core_rst_n), .led_rgb(led_rgb), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges since reset_n release
    int cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    localparam int SIG_MAIN = 0, SIG_CORE = 1, SIG_LED = 2, SIG_UART = 3,
                   SIG_LOAD = 4, SIG_BTN = 5, SIG_TMO = 6, SIG_RX = 7;

    typedef struct {
        int         cyc;
        int         sig;
        logic [2:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t sb_keep[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic string sig_name(int s);
        case (s)
            SIG_MAIN: return "main_rst_n";
            SIG_CORE: return "core_rst_n";
            SIG_LED:  return "led_rgb";
            SIG_UART: return "uart_en";
            SIG_LOAD: return "loading";
            SIG_BTN:  return "btn_db";
            SIG_TMO:  return "timeout";
            default:  return "rx_sync";
        endcase
    endfunction

    function automatic logic [2:0] sig_val(int s);
        case (s)
            SIG_MAIN: return {2'b00, main_rst_n};
            SIG_CORE: return {2'b00, core_rst_n};
            SIG_LED:  return led_rgb;
            SIG_UART: return {2'b00, uart_en};
            SIG_LOAD: return {2'b00, loading};
            SIG_BTN:  return {1'b0, btn_db};
            SIG_TMO:  return {2'b00, timeout};
            default:  return {2'b00, rx_sync};
        endcase
    endfunction

    task automatic exp_at(input int c, input int s, input logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [2:0] act;
        sb_keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                act = sig_val(sb[i].sig);
                checks++;
                if (act !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b expected=%b",
                             sig_name(sb[i].sig), cyc, act, sb[i].val);
                end
            end else if (sb[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s cyc=%0d never sampled (now cyc=%0d)",
                         sig_name(sb[i].sig), sb[i].cyc, cyc);
            end else begin
                sb_keep.push_back(sb[i]);
            end
        end
        sb = sb_keep;
    end

    initial begin
        #20000;
        $display("FAIL tb_timeout simulation ran past 20000ns, pending=%0d", sb.size());
        $fatal(1, "bench timeout");
    end

    initial begin
        // reset values
        exp_at(0, SIG_MAIN, 0); exp_at(0, SIG_CORE, 0); exp_at(0, SIG_LED, 3'b000);
        exp_at(0, SIG_UART, 0); exp_at(0, SIG_LOAD, 0); exp_at(0, SIG_BTN, 0);
        exp_at(0, SIG_TMO, 0);  exp_at(0, SIG_RX, 1);
        // release with all inputs low
        exp_at(1, SIG_RX, 1); exp_at(2, SIG_RX, 0);
        exp_at(1, SIG_UART, 0); exp_at(3, SIG_UART, 0); exp_at(4, SIG_UART, 1);
        exp_at(5, SIG_UART, 0); exp_at(8, SIG_UART, 1); exp_at(9, SIG_UART, 0);
        exp_at(12, SIG_UART, 1);
        exp_at(2, SIG_MAIN, 0); exp_at(3, SIG_MAIN, 1);
        exp_at(5, SIG_CORE, 0); exp_at(6, SIG_CORE, 1);
        exp_at(7, SIG_LED, 3'b000); exp_at(8, SIG_LED, 3'b100);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // 3-cycle glitch on sw_in must not reach loading
        wait_cyc(20);
        sw_in = 1'b1;
        exp_at(24, SIG_LOAD, 0); exp_at(26, SIG_LOAD, 0); exp_at(28, SIG_LOAD, 0);
        exp_at(28, SIG_LED, 3'b100);
        wait_cyc(23);
        sw_in = 1'b0;

        // 10-cycle load, then falling loading pulses core reset for 3 cycles
        wait_cyc(30);
        sw_in = 1'b1;
        exp_at(35, SIG_LOAD, 0); exp_at(36, SIG_LOAD, 1);
        exp_at(37, SIG_LED, 3'b100); exp_at(38, SIG_LED, 3'b010);
        wait_cyc(40);
        sw_in = 1'b0;
        exp_at(45, SIG_LOAD, 1); exp_at(46, SIG_LOAD, 0);
        exp_at(45, SIG_CORE, 1); exp_at(46, SIG_CORE, 0); exp_at(48, SIG_CORE, 0);
        exp_at(49, SIG_CORE, 1); exp_at(47, SIG_MAIN, 1);
        exp_at(47, SIG_LED, 3'b010); exp_at(48, SIG_LED, 3'b000);
        exp_at(50, SIG_LED, 3'b000); exp_at(51, SIG_LED, 3'b100);

        // main-reset button held 8 cycles
        wait_cyc(60);
        btn_in = 2'b10;
        exp_at(65, SIG_BTN, 3'b000); exp_at(66, SIG_BTN, 3'b010);
        exp_at(65, SIG_MAIN, 1); exp_at(66, SIG_MAIN, 0); exp_at(66, SIG_CORE, 0);
        exp_at(67, SIG_LED, 3'b100); exp_at(68, SIG_LED, 3'b000);
        wait_cyc(68);
        btn_in = 2'b00;
        exp_at(73, SIG_BTN, 3'b010); exp_at(74, SIG_BTN, 3'b000);
        exp_at(76, SIG_MAIN, 0); exp_at(77, SIG_MAIN, 1);
        exp_at(79, SIG_CORE, 0); exp_at(80, SIG_CORE, 1);
        exp_at(81, SIG_LED, 3'b000); exp_at(82, SIG_LED, 3'b100);

        // single-cycle done latches S_DONE
        wait_cyc(90);
        done = 1'b1;
        exp_at(91, SIG_LED, 3'b100); exp_at(92, SIG_LED, 3'b001);
        exp_at(95, SIG_LED, 3'b001); exp_at(100, SIG_LED, 3'b001);
        wait_cyc(91);
        done = 1'b0;

        // core-reset button leaves S_DONE
        wait_cyc(100);
        btn_in = 2'b01;
        exp_at(105, SIG_BTN, 3'b000); exp_at(106, SIG_BTN, 3'b001);
        exp_at(105, SIG_CORE, 1); exp_at(106, SIG_CORE, 0);
        exp_at(107, SIG_LED, 3'b001); exp_at(108, SIG_LED, 3'b000);
        wait_cyc(106);
        btn_in = 2'b00;
        exp_at(111, SIG_BTN, 3'b001); exp_at(112, SIG_BTN, 3'b000);
        exp_at(114, SIG_CORE, 0); exp_at(115, SIG_CORE, 1);
        exp_at(116, SIG_LED, 3'b000); exp_at(117, SIG_LED, 3'b100);

        // long S_RUN from cycle 116: watchdog fires after 64 cycles when built in
`ifdef BF_OVERSEER_WATCHDOG_EN
        exp_at(180, SIG_TMO, 0); exp_at(181, SIG_TMO, 1);
        exp_at(183, SIG_LED, 3'b100); exp_at(185, SIG_LED, 3'b000);
        exp_at(197, SIG_TMO, 1); exp_at(198, SIG_TMO, 0);
`else
        exp_at(181, SIG_TMO, 0); exp_at(185, SIG_LED, 3'b100);
        exp_at(197, SIG_LED, 3'b100); exp_at(198, SIG_TMO, 0);
`endif
        wait_cyc(190);
        sw_in = 1'b1;
        exp_at(196, SIG_LOAD, 1); exp_at(198, SIG_LED, 3'b010);
        wait_cyc(200);
        sw_in = 1'b0;
        exp_at(205, SIG_LOAD, 1); exp_at(206, SIG_LOAD, 0);
        exp_at(206, SIG_CORE, 0); exp_at(208, SIG_CORE, 0); exp_at(209, SIG_CORE, 1);
        exp_at(210, SIG_LED, 3'b000); exp_at(211, SIG_LED, 3'b100);

        // raw re-press of btn[0] before its debounced release
        wait_cyc(220);
        btn_in = 2'b01;
        exp_at(226, SIG_BTN, 3'b001); exp_at(226, SIG_CORE, 0);
        wait_cyc(224);
        btn_in = 2'b00;
        wait_cyc(226);
        btn_in = 2'b01;
        exp_at(230, SIG_BTN, 3'b001); exp_at(231, SIG_CORE, 0);
        wait_cyc(230);
        btn_in = 2'b00;
        exp_at(235, SIG_BTN, 3'b001); exp_at(236, SIG_BTN, 3'b000);
        exp_at(236, SIG_CORE, 0); exp_at(238, SIG_CORE, 0); exp_at(239, SIG_CORE, 1);
        exp_at(241, SIG_LED, 3'b100);

        // loading falls one cycle into the btn[0] hold: hold count restarts
        wait_cyc(250);
        sw_in = 1'b1;
        exp_at(256, SIG_LOAD, 1); exp_at(258, SIG_LED, 3'b010);
        wait_cyc(260);
        btn_in = 2'b01;
        exp_at(266, SIG_BTN, 3'b001); exp_at(266, SIG_CORE, 0);
        exp_at(268, SIG_LED, 3'b000);
        wait_cyc(270);
        btn_in = 2'b00;
        exp_at(276, SIG_BTN, 3'b000);
        wait_cyc(272);
        sw_in = 1'b0;
        exp_at(277, SIG_LOAD, 1); exp_at(278, SIG_LOAD, 0);
        exp_at(279, SIG_CORE, 0); exp_at(280, SIG_CORE, 0); exp_at(281, SIG_CORE, 1);
        exp_at(283, SIG_LED, 3'b100);
        exp_at(300, SIG_UART, 1); exp_at(301, SIG_UART, 0); exp_at(300, SIG_MAIN, 1);

        wait_cyc(305);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
